// File: rtl/block_norm_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// block_norm_if : sample stream into, and normalized frame stream out of,
//                 block_norm.                                         Rev 1.0
// -----------------------------------------------------------------------------
interface block_norm_if #(
  parameter int W     = 32,
  parameter int W_EXP = $clog2(W)
);
  logic signed [W-1:0] i_data;
  logic                i_vld;
  logic signed [W-1:0] o_data;
  logic                o_vld;
  logic                o_first;
  logic                o_last;
  logic [W_EXP-1:0]    o_exp;

  modport master (
    output i_data, i_vld,
    input  o_data, o_vld, o_first, o_last, o_exp
  );

  modport slave (
    input  i_data, i_vld,
    output o_data, o_vld, o_first, o_last, o_exp
  );
endinterface
`default_nettype wire

// File: rtl/block_norm.sv
`default_nettype none
// -----------------------------------------------------------------------------
// block_norm : block-floating-point frame normalizer with a ping-pong buffer.
//              Macro BLOCK_NORM_HEADROOM_EN keeps one guard bit.      Rev 1.0
// -----------------------------------------------------------------------------
module block_norm #(
  parameter int W     = 32,
  parameter int N     = 16,
  parameter int W_EXP = $clog2(W)
) (
  input  wire logic    clk,
  input  wire logic    rst,
  block_norm_if.slave  bus
);

  localparam int AW = $clog2(N);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Bank select is the top address bit: {bank, sample index}.
  logic [W-1:0]     frame_buf [2*N];

  logic [AW-1:0]    wr_cnt_q,   wr_cnt_d;
  logic             wr_bank_q,  wr_bank_d;
  logic [W_EXP-1:0] min_q,      min_d;
  logic [W_EXP-1:0] exp_q,      exp_d;

  state_t           state_q,    state_d;
  logic [AW-1:0]    rd_cnt_q,   rd_cnt_d;
  logic             rd_bank_q,  rd_bank_d;
  logic             rd_en;

  logic             s1_vld_q,   s1_vld_d;
  logic             s1_first_q, s1_first_d;
  logic             s1_last_q,  s1_last_d;
  logic [W-1:0]     s1_data_q,  s1_data_d;
  logic [W_EXP-1:0] s1_exp_q,   s1_exp_d;

  logic             o_vld_q,    o_vld_d;
  logic             o_first_q,  o_first_d;
  logic             o_last_q,   o_last_d;
  logic [W-1:0]     o_data_q,   o_data_d;
  logic [W_EXP-1:0] o_exp_q,    o_exp_d;

  logic             wrap;
  logic [W_EXP-1:0] sample_lsb;
  logic [W_EXP-1:0] frame_min;
  logic [W_EXP-1:0] frame_shift;

  function automatic logic [W_EXP-1:0] redundant_signs(input logic [W-1:0] x);
    logic [W_EXP-1:0] n;
    logic             run;
    n   = '0;
    run = 1'b1;
    for (int i = W - 2; i >= 0; i--) begin
      if (run && (x[i] == x[W-1])) begin
        n = n + W_EXP'(1);
      end else begin
        run = 1'b0;
      end
    end
    return n;
  endfunction

  assign sample_lsb = redundant_signs(bus.i_data);
  assign frame_min  = (sample_lsb < min_q) ? sample_lsb : min_q;
  assign wrap       = bus.i_vld && (wr_cnt_q == AW'(N - 1));

`ifdef BLOCK_NORM_HEADROOM_EN
  assign frame_shift = (frame_min != '0) ? (frame_min - W_EXP'(1)) : '0;
`else
  assign frame_shift = frame_min;
`endif

  // Write side: fill counter, running minimum, bank swap on frame completion.
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    min_d     = min_q;
    exp_d     = exp_q;
    if (bus.i_vld) begin
      wr_cnt_d = wr_cnt_q + AW'(1);
      min_d    = frame_min;
      if (wrap) begin
        wr_bank_d = ~wr_bank_q;
        min_d     = W_EXP'(W - 1);
        exp_d     = frame_shift;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus.i_vld) begin
      frame_buf[{wr_bank_q, wr_cnt_q}] <= bus.i_data;
    end
  end

  // Read FSM. A frame completing on the final drain cycle chains straight on.
  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    rd_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (wrap) begin
          state_d   = DRAIN;
          rd_cnt_d  = '0;
          rd_bank_d = wr_bank_q;
        end
      end
      DRAIN: begin
        rd_en    = 1'b1;
        rd_cnt_d = rd_cnt_q + AW'(1);
        if (rd_cnt_q == AW'(N - 1)) begin
          if (wrap) begin
            rd_cnt_d  = '0;
            rd_bank_d = wr_bank_q;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Exponent travels with each word, since exp_q may already hold the next frame's.
  always_comb begin
    s1_vld_d   = rd_en;
    s1_first_d = rd_en && (rd_cnt_q == '0);
    s1_last_d  = rd_en && (rd_cnt_q == AW'(N - 1));
    s1_data_d  = s1_data_q;
    s1_exp_d   = s1_exp_q;
    if (rd_en) begin
      s1_data_d = frame_buf[{rd_bank_q, rd_cnt_q}];
      s1_exp_d  = exp_q;
    end
  end

  always_comb begin
    o_vld_d   = s1_vld_q;
    o_first_d = s1_first_q;
    o_last_d  = s1_last_q;
    o_data_d  = o_data_q;
    o_exp_d   = o_exp_q;
    if (s1_vld_q) begin
      o_data_d = s1_data_q << s1_exp_q;
      o_exp_d  = s1_exp_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q   <= '0;
      wr_bank_q  <= 1'b0;
      min_q      <= W_EXP'(W - 1);
      exp_q      <= '0;
      state_q    <= IDLE;
      rd_cnt_q   <= '0;
      rd_bank_q  <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_data_q  <= '0;
      s1_exp_q   <= '0;
      o_vld_q    <= 1'b0;
      o_first_q  <= 1'b0;
      o_last_q   <= 1'b0;
      o_data_q   <= '0;
      o_exp_q    <= '0;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      wr_bank_q  <= wr_bank_d;
      min_q      <= min_d;
      exp_q      <= exp_d;
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_bank_q  <= rd_bank_d;
      s1_vld_q   <= s1_vld_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
      s1_data_q  <= s1_data_d;
      s1_exp_q   <= s1_exp_d;
      o_vld_q    <= o_vld_d;
      o_first_q  <= o_first_d;
      o_last_q   <= o_last_d;
      o_data_q   <= o_data_d;
      o_exp_q    <= o_exp_d;
    end
  end

  assign bus.o_vld   = o_vld_q;
  assign bus.o_first = o_first_q;
  assign bus.o_last  = o_last_q;
  assign bus.o_data  = o_data_q;
  assign bus.o_exp   = o_exp_q;

endmodule
`default_nettype wire

// File: tb/tb_block_norm.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_block_norm : frames checked against a frame-level normalization model.
//                                                                     Rev 1.0
// -----------------------------------------------------------------------------
module tb_block_norm;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int WE = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  block_norm_if #(.W(W), .W_EXP(WE)) bus ();
  block_norm #(.W(W), .N(N), .W_EXP(WE)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    int     data;
    int     ex;
    bit     first;
    bit     last;
    longint due;
  } exp_t;

  exp_t    expq[$];
  int      part[$];
  exp_t    mon_e;
  longint  cyc = 0;
  int      errors = 0;
  int      checks = 0;
  int      vld_run = 0;
  int      max_run = 0;
  logic    prev_vld = 1'b0;
  logic [WE-1:0] prev_exp = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", tag, $signed(got), $signed(want));
    end
  endtask

  // Largest k for which x * 2^k still fits in a W-bit signed word.
  function automatic int lsb_of(input int x);
    int     r;
    longint p;
    r = 0;
    for (int k = 0; k < W; k++) begin
      p = longint'(x) * (longint'(1) << k);
      if (p >= -(longint'(1) << (W - 1)) && p < (longint'(1) << (W - 1))) r = k;
    end
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin : model
    int   mn;
    int   sh;
    exp_t e;
    if (!rst && bus.i_vld) begin
      part.push_back(bus.i_data);
      if (part.size() == N) begin
        mn = W - 1;
        foreach (part[k]) if (lsb_of(part[k]) < mn) mn = lsb_of(part[k]);
`ifdef BLOCK_NORM_HEADROOM_EN
        sh = (mn > 0) ? mn - 1 : 0;
`else
        sh = mn;
`endif
        for (int k = 0; k < N; k++) begin
          e.data  = int'(longint'(part[k]) * (longint'(1) << sh));
          e.ex    = sh;
          e.first = (k == 0);
          e.last  = (k == N - 1);
          e.due   = cyc + 2 + k;
          expq.push_back(e);
        end
        part.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      vld_run  = 0;
      prev_vld = 1'b0;
    end else begin
      if (bus.o_vld) begin
        vld_run++;
        if (vld_run > max_run) max_run = vld_run;
        if (prev_vld && !bus.o_first) chk("exp_stable", bus.o_exp, prev_exp);
        if (expq.size() == 0) begin
          chk("unexpected_vld", expq.size(), 1);
        end else begin
          mon_e = expq.pop_front();
          chk("data",    $signed(bus.o_data), mon_e.data);
          chk("exp",     bus.o_exp,           mon_e.ex);
          chk("first",   bus.o_first,         mon_e.first);
          chk("last",    bus.o_last,          mon_e.last);
          chk("latency", cyc - 1,             mon_e.due);
        end
      end else begin
        vld_run = 0;
      end
      prev_vld = bus.o_vld;
      prev_exp = bus.o_exp;
    end
  end

  task automatic drive(input int x, input int gap);
    bus.i_data = x;
    bus.i_vld  = 1'b1;
    @(posedge clk); #1;
    bus.i_vld  = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send4(input int a, input int b, input int c, input int d, input int gap);
    drive(a, gap); drive(b, gap); drive(c, gap); drive(d, gap);
  endtask

  task automatic settle();
    repeat (N + 4) begin @(posedge clk); #1; end
    chk("drained", expq.size(), 0);
  endtask

  initial begin
    int base;
    int v;
    bus.i_vld  = 1'b0;
    bus.i_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld",   bus.o_vld,   0);
    chk("rst_first", bus.o_first, 0);
    chk("rst_last",  bus.o_last,  0);
    chk("rst_data",  bus.o_data,  0);
    chk("rst_exp",   bus.o_exp,   0);
    rst = 1'b0;

    max_run = 0;
    send4(1, 2, 3, -4, 0);
    settle();
    chk("run_basic", max_run, 4);

    send4(32'sh4000_0000, 0, 0, 0, 0);
    settle();
    send4(0, 0, 0, 0, 0);
    settle();
    send4(-1, -1, -1, -1, 0);
    settle();

    max_run = 0;
    for (int f = 0; f < 3; f++) send4(65535 << (3 * f), 3 << (3 * f), -(1 << (3 * f)), 0, 0);
    settle();
    chk("run_b2b", max_run, 12);

    max_run = 0;
    send4(1, 2, 3, -4, 1);
    settle();
    chk("run_gaps", max_run, 4);

    // Reset while frame A drains and frame B is half filled.
    send4(1, 2, 3, -4, 0);
    drive(5, 0);
    drive(6, 0);
    chk("pre_rst_vld", bus.o_vld, 1);
    rst = 1'b1;
    part.delete();
    expq.delete();
    #1;
    chk("arst_vld",   bus.o_vld,   0);
    chk("arst_data",  bus.o_data,  0);
    chk("arst_first", bus.o_first, 0);
    chk("arst_exp",   bus.o_exp,   0);
    @(posedge clk); #1;
    rst = 1'b0;
    max_run = 0;
    send4(1, 2, 3, -4, 0);
    settle();
    chk("run_post_rst", max_run, 4);

    for (int f = 0; f < 16; f++) begin
      base = $urandom_range(0, 28);
      for (int k = 0; k < N; k++) begin
        v = $urandom;
        v = v >>> (base + $urandom_range(0, 3));
        drive(v, $urandom_range(0, 2) == 0 ? 1 : 0);
      end
    end
    settle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/block_norm.md
# block_norm

Block-floating-point normalizer on the FFT input path, the counterpart of the output `round` stage. The block collects a frame of `N` signed samples and finds the smallest count of redundant sign bits across the frame. It then replays the frame with every sample left-shifted by that common amount, together with the shift exponent, so the FFT core uses its full word width. `round` trims the result back on the way out, and `o_exp` lets postprocessing undo the scaling.

## Interface
- `W`, default 32: sample width, signed two's complement, input and output.
- `N`, default 16: frame length in samples; a power of two, at least 2.
- `W_EXP`, default `$clog2(W)`: width of the exponent output.
- `clk`  in  1  : single clock; all logic is rising-edge.
- `rst`  in  1  : reset, asynchronous and active-high. Clears all state and outputs.
- `i_data`  in  W  : input sample, signed.
- `i_vld`  in  1  : `i_data` is valid this cycle. No backpressure; gaps between samples are allowed.
- `o_data`  out  W  : normalized sample, signed.
- `o_vld`  out  1  : output sample valid.
- `o_first`  out  1  : first sample of the output frame; qualified by `o_vld`.
- `o_last`  out  1  : last sample of the output frame; qualified by `o_vld`.
- `o_exp`  out  W_EXP  : applied left shift; constant across a frame; qualified by `o_vld`.

## Operation
- Ping-pong buffer of 2×N words.
  - The write bank fills from `i_vld` samples, addressed by a write counter from 0 to N-1.
  - The read bank drains to the output.
- Per accepted sample, compute the redundant sign bits: `lsb(x)` = (number of leading bits equal to bit W-1) − 1.
- The frame minimum is kept in a running register, reset to W-1 at the start of each frame.
- All-zero and all-ones samples give W-1, so an all-zero frame yields exp = W-1 and outputs 0. `-1` frames give exp = W-1 and output `-(1<<(W-1))`.
- When the write counter wraps from N-1 to 0:
  - the banks swap;
  - the frame exponent is latched into the exp register;
  - the read FSM starts.
- Read FSM states:
  - IDLE → DRAIN on frame completion.
  - DRAIN emits one sample per cycle, read address 0 to N-1, with no gaps.
  - DRAIN → IDLE after address N-1, unless another frame completed in the same cycle. In that case it goes directly to DRAIN on the new bank.
- Output sample = `buf[k] <<< exp`. No overflow is possible by construction of the minimum.
- Input is at most one sample per cycle, so a drain of N cycles always ends before the next fill completes. No overflow or underflow condition exists.
- A partial frame is held indefinitely until it completes. There is no flush.

## Timing
- Reset values: `o_vld`, `o_first`, `o_last` = 0; `o_data` = 0; `o_exp` = 0. Write counter, read counter, bank select and FSM go to 0 / IDLE.
- Reset mid-fill or mid-drain discards the partial frame and the in-flight output at once (asynchronously). The first frame after release starts at address 0.
- Latency: last sample of a frame sampled at edge t. Exponent latched at t. First output registered at edge t+2, so `o_vld`/`o_first` are visible after t+2. The last output is at t+N+1.
- `o_first` is high only on sample 0 and `o_last` only on sample N-1. `o_exp` is stable from `o_first` through `o_last`.
- Back-to-back frames with continuous `i_vld` give continuous `o_vld` after the initial 2-cycle latency.

## Configuration
- Macro `BLOCK_NORM_HEADROOM_EN`.
- Defined: applied shift = max(min_lsb − 1, 0). This reserves one guard bit so the first FFT butterfly cannot overflow. `o_exp` reports the reduced shift.
- Undefined: applied shift = min_lsb (full normalization).

## Test plan
- Run with N=4, W=32, no macro. Feed {1, 2, 3, -4} continuously. Required: o_exp=29; outputs 536870912, 1073741824, 1610612736, -2147483648; first output 2 cycles after the last input; o_first on sample 0, o_last on sample 3.
- Repeat the same frame with `BLOCK_NORM_HEADROOM_EN` defined. Required: o_exp=28; outputs 268435456, 536870912, 805306368, -1073741824.
- Feed frame {32'sh4000_0000, 0, 0, 0}. Required: o_exp=0; samples pass through unchanged. Then feed an all-zero frame. Required: o_exp=31, all outputs 0.
- Feed 3 frames with continuous `i_vld`, each with a different exponent (e.g. 65535-scaled values). Required: `o_vld` gap-free for 12 cycles, and `o_exp` switches exactly at each `o_first`.
- Feed a frame with 1-cycle `i_vld` gaps between samples. Required: output is still 4 contiguous `o_vld` cycles, with the same values as the gap-free case.
- Assert `rst` after 2 of 4 samples, release it, then feed a full frame {1, 2, 3, -4}. Required: outputs drop to 0 immediately; the next output frame matches scenario 1 exactly, with no stale samples.
